// File: rtl/sigdelay_pkg.sv
// Shared types and constants for the signal-delay sample store.
// MIDSCALE is the silent level of the 8-bit unsigned audio path.
package sigdelay_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } dly_state_t;

    localparam logic [7:0] MIDSCALE = 8'h80;

    // Fill count at which every location has been written once.
    function automatic logic [31:0] full_count(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one synchronous write port and one synchronous read-first read port.
// The array has no reset so it maps onto block RAM.
module dual_port_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port; a same-address read in this edge still sees the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port register, held while the read enable is low.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sig_delay_buffer.sv
// Circular sample store: writes the mic sample at wr_addr and reads the delayed sample at rd_addr
// on every strobe; output is muted to midscale until each location has been written once.
module sig_delay_buffer
    import sigdelay_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  freeze,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  primed
);

    localparam logic [ADDR_WIDTH:0]   FILL_DONE = (ADDR_WIDTH+1)'(full_count(ADDR_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MID_LEVEL = DATA_WIDTH'(MIDSCALE);

    dly_state_t            state_q, state_d;
    logic [ADDR_WIDTH:0]   fill_cnt_q, fill_cnt_d;
    logic                  primed_q, primed_d;
    logic                  valid_q, valid_d;
    logic                  show_q, show_d;
    logic                  we_s;
    logic                  re_s;
    logic [DATA_WIDTH-1:0] rdata_s;

    // Next-state, fill counting and RAM port enables.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        primed_d   = primed_q;
        valid_d    = 1'b0;
        show_d     = show_q;
        we_s       = 1'b0;
        re_s       = 1'b0;
        case (state_q)
            FILL: begin
                if (en && !freeze) begin
                    we_s       = 1'b1;
                    fill_cnt_d = fill_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    if (fill_cnt_d == FILL_DONE) begin
                        state_d  = RUN;
                        primed_d = 1'b1;
                    end else begin
                        state_d  = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                // The strobe on which freeze rises still writes: the state is RUN at that edge.
                if (en) begin
                    we_s    = 1'b1;
                    re_s    = 1'b1;
                    valid_d = 1'b1;
                    show_d  = 1'b1;
                end else begin
                    we_s    = 1'b0;
                end
                if (freeze) begin
                    state_d = FROZEN;
                end else begin
                    state_d = RUN;
                end
            end
            FROZEN: begin
                if (en) begin
                    re_s    = 1'b1;
                    valid_d = 1'b1;
                    show_d  = 1'b1;
                end else begin
                    re_s    = 1'b0;
                end
                if (!freeze) begin
                    state_d = RUN;
                end else begin
                    state_d = FROZEN;
                end
            end
            default: begin
                state_d    = FILL;
                fill_cnt_d = '0;
                primed_d   = 1'b0;
                show_d     = 1'b0;
            end
        endcase
    end

    // State and control registers; memory contents survive reset and are masked by FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            primed_q   <= 1'b0;
            valid_q    <= 1'b0;
            show_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            primed_q   <= primed_d;
            valid_q    <= valid_d;
            show_q     <= show_d;
        end
    end

    dual_port_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (wr_addr),
        .wdata_i (din),
        .re_i    (re_s),
        .raddr_i (rd_addr),
        .rdata_o (rdata_s)
    );

    // The RAM read register is the output register; show_q selects it once a primed read has landed.
    assign dout       = show_q ? rdata_s : MID_LEVEL;
    assign dout_valid = valid_q;
    assign primed     = primed_q;

endmodule

// File: tb/tb_sig_delay_buffer.sv
// Directed self-checking bench for sig_delay_buffer: reset, fill, delay, collision, freeze, mid-run reset.
module tb_sig_delay_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [8:0] wr_addr;
    logic [8:0] rd_addr;
    logic [7:0] din;
    logic       freeze;
    logic [7:0] dout;
    logic       dout_valid;
    logic       primed;

    int tests_run    = 0;
    int tests_failed = 0;

    sig_delay_buffer #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .din        (din),
        .freeze     (freeze),
        .dout       (dout),
        .dout_valid (dout_valid),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic e, input logic [8:0] wa, input logic [8:0] ra,
                        input logic [7:0] d, input logic fr);
        en      = e;
        wr_addr = wa;
        rd_addr = ra;
        din     = d;
        freeze  = fr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_dout,
                             input logic exp_valid, input logic exp_primed);
        check({tag, ".dout"}, {24'd0, dout}, {24'd0, exp_dout});
        check({tag, ".valid"}, {31'd0, dout_valid}, {31'd0, exp_valid});
        check({tag, ".primed"}, {31'd0, primed}, {31'd0, exp_primed});
    endtask

    logic [7:0] frozen_exp [0:9];

    initial begin
        rst = 1'b1; en = 1'b0; wr_addr = 9'd0; rd_addr = 9'd0; din = 8'd0; freeze = 1'b0;

        // Reset held two cycles, then again with strobes active.
        step(1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
        step(1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
        check_out("reset", 8'h80, 1'b0, 1'b0);
        step(1'b1, 9'd3, 9'd1, 8'h11, 1'b0);
        step(1'b1, 9'd4, 9'd2, 8'h22, 1'b0);
        check_out("reset_en", 8'h80, 1'b0, 1'b0);
        rst = 1'b0;

        // Fill 511 locations with din = low byte of address; one frozen strobe mid-fill is ignored.
        for (int i = 0; i < 511; i++) begin
            if (i == 100) begin
                step(1'b1, 9'd100, 9'd0, 8'hEE, 1'b1);
                check_out("fill_frz", 8'h80, 1'b0, 1'b0);
            end
            step(1'b1, 9'(i), 9'd0, 8'(i), 1'b0);
            check_out("fill", 8'h80, 1'b0, 1'b0);
        end
        step(1'b1, 9'd511, 9'd0, 8'hFF, 1'b0);
        check_out("fill_512", 8'h80, 1'b0, 1'b1);

        // First primed strobe: read 0x040 from the previous lap.
        step(1'b1, 9'h000, 9'h040, 8'hAA, 1'b0);
        check_out("delay", 8'h40, 1'b1, 1'b1);
        step(1'b0, 9'h000, 9'h000, 8'h00, 1'b0);
        check_out("idle_hold", 8'h40, 1'b0, 1'b1);

        // Same-address collision is read-first.
        step(1'b1, 9'h005, 9'h005, 8'h55, 1'b0);
        check_out("collide_old", 8'h05, 1'b1, 1'b1);
        step(1'b1, 9'h006, 9'h005, 8'h66, 1'b0);
        check_out("collide_new", 8'h55, 1'b1, 1'b1);
        step(1'b1, 9'h007, 9'h000, 8'h77, 1'b0);
        check_out("read_aa", 8'hAA, 1'b1, 1'b1);

        // Freeze: writes of 0xFF to 0..9 are dropped, reads continue.
        for (int i = 0; i < 10; i++) frozen_exp[i] = 8'(i);
        frozen_exp[0] = 8'hAA; frozen_exp[5] = 8'h55; frozen_exp[6] = 8'h66; frozen_exp[7] = 8'h77;
        step(1'b0, 9'd0, 9'd0, 8'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 9'(i), 9'(i), 8'hFF, 1'b1);
            check_out("frz_wr", frozen_exp[i], 1'b1, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 9'(9'h100 + i), 9'(i), 8'hFF, 1'b1);
            check_out("frz_rd", frozen_exp[i], 1'b1, 1'b1);
        end

        // Release: writes resume.
        step(1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
        step(1'b1, 9'h003, 9'h1F0, 8'hC3, 1'b0);
        check_out("rel_rd", 8'hF0, 1'b1, 1'b1);
        step(1'b1, 9'h1F1, 9'h003, 8'h31, 1'b0);
        check_out("rel_wr", 8'hC3, 1'b1, 1'b1);

        // Strobe on which freeze rises still writes; the next one does not.
        step(1'b1, 9'h008, 9'h1F2, 8'h88, 1'b1);
        check_out("frz_edge", 8'hF2, 1'b1, 1'b1);
        step(1'b1, 9'h009, 9'h008, 8'h99, 1'b1);
        check_out("frz_edge_wr", 8'h88, 1'b1, 1'b1);
        step(1'b1, 9'h1F3, 9'h009, 8'h00, 1'b1);
        check_out("frz_edge_nowr", 8'h09, 1'b1, 1'b1);

        // Mid-run reset: back to muted fill, 512 writes needed again.
        step(1'b0, 9'd0, 9'd0, 8'd0, 1'b0);
        rst = 1'b1;
        step(1'b1, 9'd0, 9'd0, 8'd0, 1'b0);
        check_out("midrst", 8'h80, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 511; i++) begin
            step(1'b1, 9'(i), 9'h1F1, 8'(i), 1'b0);
            check_out("refill", 8'h80, 1'b0, 1'b0);
        end
        step(1'b1, 9'd511, 9'h000, 8'hFF, 1'b0);
        check_out("refill_512", 8'h80, 1'b0, 1'b1);
        step(1'b1, 9'h000, 9'h1F1, 8'h01, 1'b0);
        check_out("refill_rd", 8'hF1, 1'b1, 1'b1);
        step(1'b0, 9'h000, 9'h000, 8'h00, 1'b0);
        check_out("refill_idle", 8'hF1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sig_delay_buffer.md
# sig_delay_buffer

Circular sample store for the signal-delay path: sits directly downstream of the dual-output address counter and consumes its two addresses. On every sample strobe it writes the incoming mic sample at `wr_addr` and reads the stored sample at `rd_addr`, producing a sample delayed by the address difference. A small state machine mutes the output until every location has been written once, and supports freezing the buffer for display.

## Interface
- `ADDR_WIDTH`, default 9: address width; depth is 2^ADDR_WIDTH = 512.
- `DATA_WIDTH`, default 8: sample width, matching the 8-bit Vbuddy data path.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `en`  in  1  sample strobe, the same enable that advances the counter; inputs are sampled only when `en`=1.
- `wr_addr`  in  ADDR_WIDTH  write address (counter output 1).
- `rd_addr`  in  ADDR_WIDTH  read address (counter output 2).
- `din`  in  DATA_WIDTH  mic sample to store.
- `freeze`  in  1  level: while high, writes are suppressed and reads continue.
- `dout`  out  DATA_WIDTH  registered delayed sample; MIDSCALE (8'h80) when not primed.
- `dout_valid`  out  1  one-cycle pulse marking a new `dout`.
- `primed`  out  1  high once 2^ADDR_WIDTH writes have completed since reset.

## Operation
- States: FILL, RUN, FROZEN. Reset enters FILL.
- FILL:
  - Each `en` with `freeze`=0 writes `din` to `mem[wr_addr]` and increments `fill_cnt`, which is ADDR_WIDTH+1 bits wide.
  - `freeze`=1 in FILL suppresses the write and holds `fill_cnt`; the block stays in FILL.
  - Exit to RUN on the write that makes `fill_cnt` = 2^ADDR_WIDTH.
  - `dout` is held at MIDSCALE and `dout_valid` stays 0.
- RUN:
  - Each `en` writes `mem[wr_addr]` and reads `mem[rd_addr]`.
  - `dout` loads the read data and `dout_valid` pulses.
  - `freeze`=1 moves to FROZEN.
- FROZEN:
  - No writes. Each `en` still reads and updates `dout`, and `dout_valid` pulses.
  - `freeze`=0 returns to RUN.
- The `freeze` transition takes effect on the next edge. The `en` cycle on which `freeze` first rises still writes only if the state is RUN at that edge.
- Read-during-write to the same address is read-first: `dout` gets the old contents.
- Addresses wrap naturally modulo 2^ADDR_WIDTH; the block does no address arithmetic.
- Effective delay is (wr_addr − rd_addr) mod 512 samples. Equal addresses give a 512-sample delay.
- `rst` mid-operation:
  - Returns to FILL, clears `fill_cnt`, and drives `primed`=0, `dout`=MIDSCALE, `dout_valid`=0.
  - Memory contents are not cleared; they are masked by the FILL state.
- `en`=0: no write, no read; `dout` holds and `dout_valid`=0.

## Timing
- Reset values: `dout`=8'h80, `dout_valid`=0, `primed`=0, state FILL, `fill_cnt`=0.
- Write latency: data lands in memory at the edge where `en`=1.
- Read latency: 1 cycle. `dout`/`dout_valid` update at the edge ending the `en` cycle and are visible in the following cycle.
- `primed` rises at the edge of the 512th accepted write. The first `dout_valid` comes from the next `en`.
- `dout_valid` is high for exactly one cycle per accepted `en`. Back-to-back `en` gives continuous `dout_valid`.

## Structure
- Package `sigdelay_pkg` holds:
  - `typedef enum logic [1:0] {FILL, RUN, FROZEN} dly_state_t`;
  - `localparam MIDSCALE = 8'h80`.
- Sub-module `dual_port_ram`:
  - parameters ADDR_WIDTH and DATA_WIDTH;
  - synchronous write port with write enable;
  - synchronous read-first read port with read enable;
  - no reset on the array.
- Top level contains only the FSM, `fill_cnt`, the output register and the RAM instance.

## Test plan
- Reset: hold `rst` 2 cycles → `dout`=0x80, `dout_valid`=0, `primed`=0. Repeat with `en`=1 during reset → no change.
- Fill:
  - Stimulus: 511 strobes with `din`=`wr_addr`[7:0] → `primed`=0, no `dout_valid`.
  - 512th strobe → `primed`=1 at that edge.
  - Next strobe → `dout_valid` pulse.
- Delay: after priming, `wr_addr`=0x000 with `din`=0xAA and `rd_addr`=0x040 → `dout`=0x40, the previous-lap value, one cycle later.
- Same-address collision: `wr_addr`=`rd_addr`=0x005, `din`=0x55, old contents 0x05 → `dout`=0x05; a later read of 0x005 → 0x55.
- Freeze:
  - Hold `freeze`=1 in RUN and write 0xFF at addresses 0–9 → reads of 0–9 return the previous contents, with `dout_valid` still pulsing.
  - Release `freeze` → writes resume.
- Mid-run reset: `rst` pulse in RUN → `primed`=0 and `dout`=0x80; 512 new strobes are required before `dout_valid` recurs.
